// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS datapath and its microprogrammed controller:
// control-word bit positions, mux/ALU encodings and the ALU control decode.
package mc_pkg;

    localparam int CW_WIDTH       = 18;
    localparam int CW_PCWRITE     = 17;
    localparam int CW_PCWRITECOND = 16;
    localparam int CW_IORD        = 15;
    localparam int CW_MEMREAD     = 14;
    localparam int CW_MEMWRITE    = 13;
    localparam int CW_IRWRITE     = 12;
    localparam int CW_MEMTOREG    = 11;
    localparam int CW_PCSOURCE    = 9;
    localparam int CW_ALUOP       = 7;
    localparam int CW_ALUSRCB     = 5;
    localparam int CW_ALUSRCA     = 4;
    localparam int CW_REGWRITE    = 3;
    localparam int CW_REGDST      = 2;
    localparam int CW_ADDRCTL     = 0;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_srcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pc_source_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ADD2  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctl_e;

    // Unknown funct codes fall back to add rather than trapping.
    function automatic alu_ctl_e alu_decode(input alu_op_e aluop, input logic [5:0] funct);
        alu_ctl_e ctl;
        ctl = ALU_ADD;
        unique case (aluop)
            ALUOP_SUB: ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct)
                    FUNCT_SUB: ctl = ALU_SUB;
                    FUNCT_AND: ctl = ALU_AND;
                    FUNCT_OR:  ctl = ALU_OR;
                    FUNCT_SLT: ctl = ALU_SLT;
                    default:   ctl = ALU_ADD;
                endcase
            end
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mc_datapath_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// synchronous clear, register 0 reads as zero and ignores writes.
module mc_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // A same-cycle read of the register being written sees the pre-edge value.
    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath driven by the 18-bit microcode control word; returns the
// current opcode to the controller and talks to a unified combinational-read memory.
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CW_WIDTH-1:0] control,
    output logic [5:0]          op,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                mem_re,
    output logic                mem_we,
    input  logic [31:0]         mem_rdata,
    output logic [31:0]         pc_out
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, mdr_q, a_q, b_q, alu_out_q;
    logic [31:0] rd1, rd2;
    logic [31:0] src_a, src_b, imm_ext, alu_result;
    logic        zero;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    alu_ctl_e    alu_ctl;
    logic        unused_addrctl;

    wire pc_write      = control[CW_PCWRITE];
    wire pc_write_cond = control[CW_PCWRITECOND];
    wire iord          = control[CW_IORD];
    wire ir_write      = control[CW_IRWRITE];
    wire mem_to_reg    = control[CW_MEMTOREG];
    wire alu_src_a     = control[CW_ALUSRCA];
    wire reg_write     = control[CW_REGWRITE];
    wire reg_dst       = control[CW_REGDST];

    pc_source_e pc_source;
    alu_op_e    alu_op;
    alu_srcb_e  alu_src_b;

    assign pc_source      = pc_source_e'(control[CW_PCSOURCE +: 2]);
    assign alu_op         = alu_op_e'(control[CW_ALUOP +: 2]);
    assign alu_src_b      = alu_srcb_e'(control[CW_ALUSRCB +: 2]);
    assign unused_addrctl = ^control[CW_ADDRCTL +: 2];

    assign wr_addr = reg_dst ? ir_q[15:11] : ir_q[20:16];
    assign wr_data = mem_to_reg ? mdr_q : alu_out_q;

    mc_regfile #(.NREGS(NREGS)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (ir_q[25:21]),
        .ra2_i (ir_q[20:16]),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .we_i  (reg_write),
        .wa_i  (wr_addr),
        .wd_i  (wr_data)
    );

    assign imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign src_a   = alu_src_a ? a_q : pc_q;
    assign alu_ctl = alu_decode(alu_op, ir_q[5:0]);

    always_comb begin
        src_b = b_q;
        unique case (alu_src_b)
            SRCB_FOUR:    src_b = 32'd4;
            SRCB_IMM:     src_b = imm_ext;
            SRCB_IMM_SH2: src_b = {imm_ext[29:0], 2'b00};
            default:      src_b = b_q;
        endcase
    end

    always_comb begin
        alu_result = src_a + src_b;
        unique case (alu_ctl)
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
            default: alu_result = src_a + src_b;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    // The reserved PCSource encoding leaves the PC alone even when a write is enabled.
    always_comb begin
        pc_d = pc_q;
        if (pc_write || (pc_write_cond && zero)) begin
            unique case (pc_source)
                PCSRC_ALU:    pc_d = alu_result;
                PCSRC_ALUOUT: pc_d = alu_out_q;
                PCSRC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                default:      pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
        end else begin
            pc_q      <= pc_d;
            mdr_q     <= mem_rdata;
            a_q       <= rd1;
            b_q       <= rd2;
            alu_out_q <= alu_result;
            if (ir_write) begin
                ir_q <= mem_rdata;
            end
        end
    end

    assign op        = ir_q[31:26];
    assign pc_out    = pc_q;
    assign mem_addr  = iord ? alu_out_q : pc_q;
    assign mem_wdata = b_q;
    assign mem_we    = control[CW_MEMWRITE];
    assign mem_re    = control[CW_MEMREAD] & ~control[CW_MEMWRITE];

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: drives microcode sequences cycle by cycle and
// compares architectural effects against a register/PC model kept in the bench.
module tb_mc_datapath;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   localparam logic [17:0] PCW  = 18'h1 << 17;
   localparam logic [17:0] PCWC = 18'h1 << 16;
   localparam logic [17:0] IORD = 18'h1 << 15;
   localparam logic [17:0] MR   = 18'h1 << 14;
   localparam logic [17:0] MW   = 18'h1 << 13;
   localparam logic [17:0] IRW  = 18'h1 << 12;
   localparam logic [17:0] M2R  = 18'h1 << 11;
   localparam logic [17:0] SRCA = 18'h1 << 4;
   localparam logic [17:0] RW   = 18'h1 << 3;
   localparam logic [17:0] RDST = 18'h1 << 2;
   localparam logic [17:0] FETCH_CW = PCW | MR | IRW | (18'd1 << 5);

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] control;
   logic [5:0]  op;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
   logic        mem_re, mem_we;

   int          nChecks = 0;
   int          nFails  = 0;
   logic [31:0] mRegs [32];
   logic [31:0] mPc;

   mc_datapath #(.RESET_PC(RST_PC), .NREGS(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .control   (control),
      .op        (op),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .pc_out    (pc_out)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] pcs(input int n);
      return 18'(n) << 9;
   endfunction
   function automatic logic [17:0] aluop(input int n);
      return 18'(n) << 7;
   endfunction
   function automatic logic [17:0] srcb(input int n);
      return 18'(n) << 5;
   endfunction

   // Reference ALU written straight from the arithmetic rules for R-type funct codes.
   function automatic logic [31:0] aluModel(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      case (f)
         6'h22:   return x - y;
         6'h24:   return x & y;
         6'h25:   return x | y;
         6'h2A:   return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
         default: return x + y;
      endcase
   endfunction

   task automatic drive(input logic [17:0] c, input logic [31:0] d);
      @(negedge clk);
      control   = c;
      mem_rdata = d;
      #1;
   endtask

   // Observes a register through B: load IR with rt=r, let B latch, then read mem_wdata.
   task automatic readReg(input logic [4:0] r, output logic [31:0] val);
      drive(IRW, {6'h00, 5'd0, r, 16'h0000});
      drive('0, '0);
      drive('0, '0);
      val = mem_wdata;
   endtask

   task automatic setReg(input logic [4:0] r, input logic [31:0] v);
      drive(IRW, {6'h23, 5'd0, r, 16'h0000});
      drive('0, v);
      drive(RW | M2R, '0);
      if (r != 5'd0) mRegs[r] = v;
   endtask

   task automatic setPc(input logic [31:0] p);
      drive(IRW, {6'h02, p[27:2]});
      drive(PCW | pcs(2), '0);
      mPc = {mPc[31:28], p[27:2], 2'b00};
   endtask

   task automatic runRtype(input logic [31:0] instr);
      drive(FETCH_CW, instr);
      mPc = mPc + 32'd4;
      drive(srcb(3), '0);
      drive(SRCA | aluop(2), '0);
      drive(RW | RDST, '0);
   endtask

   task automatic test_reset;
      logic [31:0] v;
      rst = 1'b1; control = '0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) mRegs[i] = '0;
      mPc = RST_PC;
      nChecks++; if (pc_out !== RST_PC) begin nFails++; $display("[TB] FAIL reset_pc: got %h expected %h", pc_out, RST_PC); end
      nChecks++; if (op !== 6'h00) begin nFails++; $display("[TB] FAIL reset_op: got %h expected 00", op); end
      nChecks++; if (mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL reset_we: got %b expected 0", mem_we); end
      for (int r = 1; r < 32; r++) begin
         readReg(5'(r), v);
         nChecks++; if (v !== 32'd0) begin nFails++; $display("[TB] FAIL reset_reg%0d: got %h expected 0", r, v); end
      end
   endtask

   task automatic test_fetch;
      drive(FETCH_CW, 32'h8C22_0004);
      nChecks++; if (mem_re !== 1'b1) begin nFails++; $display("[TB] FAIL fetch_re: got %b expected 1", mem_re); end
      nChecks++; if (mem_addr !== mPc) begin nFails++; $display("[TB] FAIL fetch_addr: got %h expected %h", mem_addr, mPc); end
      mPc = mPc + 32'd4;
      drive('0, '0);
      nChecks++; if (op !== 6'h23) begin nFails++; $display("[TB] FAIL fetch_op: got %h expected 23", op); end
      nChecks++; if (pc_out !== mPc) begin nFails++; $display("[TB] FAIL fetch_pc: got %h expected %h", pc_out, mPc); end
   endtask

   task automatic test_lw;
      logic [31:0] v;
      setReg(5'd1, 32'h0000_0200);
      drive(FETCH_CW, 32'h8C22_0004);
      mPc = mPc + 32'd4;
      drive(srcb(3), '0);
      drive(SRCA | srcb(2), '0);
      drive(IORD | MR, 32'hDEAD_BEEF);
      nChecks++; if (mem_addr !== 32'h0000_0204) begin nFails++; $display("[TB] FAIL lw_addr: got %h expected 00000204", mem_addr); end
      nChecks++; if (mem_re !== 1'b1) begin nFails++; $display("[TB] FAIL lw_re: got %b expected 1", mem_re); end
      drive(RW | M2R, '0);
      mRegs[2] = 32'hDEAD_BEEF;
      readReg(5'd2, v);
      nChecks++; if (v !== mRegs[2]) begin nFails++; $display("[TB] FAIL lw_r2: got %h expected %h", v, mRegs[2]); end
      nChecks++; if (pc_out !== mPc) begin nFails++; $display("[TB] FAIL lw_pc: got %h expected %h", pc_out, mPc); end
   endtask

   task automatic test_beq;
      logic [31:0] v;
      for (int taken = 1; taken >= 0; taken--) begin
         v = $urandom;
         setReg(5'd3, v);
         setReg(5'd4, (taken != 0) ? v : (v ^ (32'h1 << $urandom_range(0, 31))));
         setPc(32'h0000_0104);
         drive(FETCH_CW, 32'h1064_FFFF);
         nChecks++; if (mem_addr !== 32'h0000_0104) begin nFails++; $display("[TB] FAIL beq_fetch_addr: got %h expected 00000104", mem_addr); end
         mPc = 32'h0000_0108;
         drive(srcb(3), '0);
         nChecks++; if (pc_out !== mPc) begin nFails++; $display("[TB] FAIL beq_decode_pc: got %h expected %h", pc_out, mPc); end
         drive(SRCA | aluop(1) | PCWC | pcs(1), '0);
         drive('0, '0);
         if (taken != 0) mPc = 32'h0000_0104;
         nChecks++; if (pc_out !== mPc) begin nFails++; $display("[TB] FAIL beq_pc_taken%0d: got %h expected %h", taken, pc_out, mPc); end
      end
   endtask

   task automatic test_rtype;
      logic [31:0] v;
      setReg(5'd5, $urandom | 32'h1);
      setReg(5'd6, 32'h0);
      runRtype({6'h00, 5'd5, 5'd6, 5'd0, 5'd0, 6'h22});
      readReg(5'd0, v);
      nChecks++; if (v !== 32'd0) begin nFails++; $display("[TB] FAIL rtype_r0: got %h expected 0", v); end
      setReg(5'd5, 32'hFFFF_FFFF);
      setReg(5'd6, 32'h0000_0001);
      runRtype({6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h2A});
      readReg(5'd7, v);
      nChecks++; if (v !== 32'd1) begin nFails++; $display("[TB] FAIL rtype_slt: got %h expected 1", v); end
      setReg(5'd9, 32'h7FFF_FFFF);
      setReg(5'd10, 32'h0000_0001);
      runRtype({6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20});
      readReg(5'd8, v);
      nChecks++; if (v !== 32'h8000_0000) begin nFails++; $display("[TB] FAIL rtype_wrap: got %h expected 80000000", v); end
   endtask

   task automatic test_random_alu;
      logic [5:0]  functs [6];
      logic [4:0]  rs, rt, rd;
      logic [5:0]  f;
      logic [31:0] v, exp;
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26};
      for (int n = 0; n < 20; n++) begin
         rs = 5'($urandom_range(1, 31));
         rt = 5'($urandom_range(1, 31));
         rd = 5'($urandom_range(0, 31));
         f  = functs[$urandom_range(0, 5)];
         setReg(rs, $urandom);
         setReg(rt, $urandom);
         runRtype({6'h00, rs, rt, rd, 5'd0, f});
         exp = (rd == 5'd0) ? 32'd0 : aluModel(f, mRegs[rs], mRegs[rt]);
         if (rd != 5'd0) mRegs[rd] = exp;
         nChecks++; if (pc_out !== mPc) begin nFails++; $display("[TB] FAIL rand_pc%0d: got %h expected %h", n, pc_out, mPc); end
         readReg(rd, v);
         nChecks++; if (v !== exp) begin nFails++; $display("[TB] FAIL rand_alu%0d f=%h: got %h expected %h", n, f, v, exp); end
      end
   endtask

   task automatic test_edge_cases;
      drive(MR | MW, '0);
      nChecks++; if (mem_re !== 1'b0) begin nFails++; $display("[TB] FAIL rdwr_re: got %b expected 0", mem_re); end
      nChecks++; if (mem_we !== 1'b1) begin nFails++; $display("[TB] FAIL rdwr_we: got %b expected 1", mem_we); end
      drive(PCW | pcs(3) | srcb(1), '0);
      drive('0, '0);
      nChecks++; if (pc_out !== mPc) begin nFails++; $display("[TB] FAIL pcsrc_rsvd: got %h expected %h", pc_out, mPc); end
   endtask

   task automatic test_mid_reset;
      logic [31:0] v;
      setReg(5'd11, $urandom | 32'h1);
      drive(FETCH_CW, 32'h8D6C_0008);
      drive(srcb(3), '0);
      drive(SRCA | srcb(2), '0);
      @(negedge clk);
      rst = 1'b1; control = '0; mem_rdata = $urandom;
      @(negedge clk);
      rst = 1'b0; control = IORD; mem_rdata = '0;
      #1;
      for (int i = 0; i < 32; i++) mRegs[i] = '0;
      mPc = RST_PC;
      nChecks++; if (pc_out !== RST_PC) begin nFails++; $display("[TB] FAIL midrst_pc: got %h expected %h", pc_out, RST_PC); end
      nChecks++; if (op !== 6'h00) begin nFails++; $display("[TB] FAIL midrst_op: got %h expected 00", op); end
      nChecks++; if (mem_addr !== 32'd0) begin nFails++; $display("[TB] FAIL midrst_aluout: got %h expected 0", mem_addr); end
      nChecks++; if (mem_wdata !== 32'd0) begin nFails++; $display("[TB] FAIL midrst_b: got %h expected 0", mem_wdata); end
      readReg(5'd11, v);
      nChecks++; if (v !== 32'd0) begin nFails++; $display("[TB] FAIL midrst_r11: got %h expected 0", v); end
   endtask

   initial begin
      $display("[TB] mc_datapath bench starting");
      test_reset;
      test_fetch;
      test_lw;
      test_beq;
      test_rtype;
      test_random_alu;
      test_edge_cases;
      test_mid_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
